// File: rtl/mult_div_seq_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer: FSM state
// encoding, the mode constants the control unit drives, and sign helpers.
package mdu_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIXUP,
        S_DONE
    } mdu_state_t;

    localparam logic MDU_MULT = 1'b0;
    localparam logic MDU_DIV  = 1'b1;

    // Widest value the sign helpers handle. Callers zero-extend into this
    // width and truncate the result back. Two's-complement negation is exact
    // modulo 2^n, so the low bits are correct for any narrower operand.
    localparam int MDU_MAX_W = 128;

    function automatic logic [MDU_MAX_W-1:0] mdu_neg(input logic [MDU_MAX_W-1:0] x);
        return ~x + MDU_MAX_W'(1);
    endfunction

    function automatic logic [MDU_MAX_W-1:0] mdu_mag(input logic [MDU_MAX_W-1:0] x,
                                                     input logic               neg);
        return neg ? mdu_neg(x) : x;
    endfunction

endpackage

// File: rtl/mult_div_seq_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, then keep the difference only if the divisor fits.
module mdu_div_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // Trial subtraction; a clear borrow bit means the divisor fits
    always_comb begin
        shifted = {rem_in, dividend_bit};
        diff    = shifted - {2'b00, divisor};
        q_bit   = ~diff[WIDTH+1];
        rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/mult_div_seq.sv
// Iterative MULT/DIV sequencer with a start/done handshake. It runs an
// LSB-first shift-add multiply or a restoring divide on operand magnitudes,
// then applies the signs in a single fixup cycle.
module mult_div_seq
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int AW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    mdu_state_t      state;
    logic [CW-1:0]   cnt;
    logic            mode_q;
    logic            neg_res;
    logic            neg_rem;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide: low half is the dividend shifting out and quotient shifting in.
    logic [AW-1:0]   acc;
    // Multiplicand for multiply, divisor for divide
    logic [WIDTH-1:0] opnd;
    logic [WIDTH:0]   rem;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_nxt;
    logic             q_bit;
    logic [AW-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    mdu_div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem_in      (rem),
        .dividend_bit(acc[WIDTH-1]),
        .divisor     (opnd),
        .rem_out     (rem_nxt),
        .q_bit       (q_bit)
    );

    // Operand magnitudes, multiply add step and sign fixup values
    always_comb begin
        a_mag    = WIDTH'(mdu_mag(MDU_MAX_W'(a), is_signed & a[WIDTH-1]));
        b_mag    = WIDTH'(mdu_mag(MDU_MAX_W'(b), is_signed & b[WIDTH-1]));
        mul_sum  = {1'b0, acc[AW-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
        prod_fix = neg_res ? AW'(mdu_neg(MDU_MAX_W'(acc))) : acc;
        quo_fix  = neg_res ? WIDTH'(mdu_neg(MDU_MAX_W'(acc[WIDTH-1:0]))) : acc[WIDTH-1:0];
        rem_fix  = neg_rem ? WIDTH'(mdu_neg(MDU_MAX_W'(rem[WIDTH-1:0]))) : rem[WIDTH-1:0];
    end

    // Sequencer FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            mode_q  <= MDU_MULT;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            acc     <= '0;
            opnd    <= '0;
            rem     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            div0    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            div0 <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q  <= mode;
                        neg_res <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem <= is_signed & a[WIDTH-1];
                        cnt     <= '0;
                        rem     <= '0;
                        busy    <= 1'b1;
                        if (mode == MDU_DIV && b == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            div0  <= 1'b1;
                        end else begin
                            state <= S_CALC;
                            opnd  <= (mode == MDU_DIV) ? b_mag : a_mag;
                            acc   <= AW'((mode == MDU_DIV) ? a_mag : b_mag);
                        end
                    end
                end
                S_CALC: begin
                    if (mode_q == MDU_MULT) begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end else begin
                        rem            <= rem_nxt;
                        acc[WIDTH-1:0] <= {acc[WIDTH-2:0], q_bit};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    if (mode_q == MDU_MULT) begin
                        hi <= prod_fix[AW-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_seq.sv
// Scoreboard bench for mult_div_seq at WIDTH=32 and WIDTH=8.
module tb_mult_div_seq;
    import mdu_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div0;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic        start32 = 1'b0, mode32 = 1'b0, sg32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32, div0_32;
    logic [31:0] hi32, lo32;

    logic        start8 = 1'b0, mode8 = 1'b0, sg8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, div0_8;
    logic [7:0]  hi8, lo8;

    exp_t q32[$];
    exp_t q8[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   ndone32 = 0;
    int   ndone8 = 0;
    logic [31:0] last_hi32 = '0, last_lo32 = '0;
    logic [7:0]  last_hi8 = '0, last_lo8 = '0;

    mult_div_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .mode(mode32), .is_signed(sg32),
        .a(a32), .b(b32), .busy(busy32), .done(done32), .div0(div0_32),
        .hi(hi32), .lo(lo32)
    );

    mult_div_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .mode(mode8), .is_signed(sg8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .div0(div0_8),
        .hi(hi8), .lo(lo8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Scoreboard for the 32-bit instance: pop on every done pulse
    always @(negedge clk) begin
        if (done32) begin
            exp_t e;
            ndone32++;
            if (q32.size() == 0) begin
                checks++;
                $display("FAIL spurious_done32: done at cycle %0d with nothing outstanding", cyc);
            end else begin
                e = q32.pop_front();
                checks++;
                if ({hi32, lo32, div0_32} !== {e.hi, e.lo, e.div0})
                    $display("FAIL %s: got hi=%h lo=%h div0=%b, expected hi=%h lo=%h div0=%b",
                             e.name, hi32, lo32, div0_32, e.hi, e.lo, e.div0);
                else passes++;
                checks++;
                if (cyc != e.due)
                    $display("FAIL %s_latency: done at cycle %0d, expected cycle %0d", e.name, cyc, e.due);
                else passes++;
            end
        end
    end

    // Scoreboard for the 8-bit instance
    always @(negedge clk) begin
        if (done8) begin
            exp_t e;
            ndone8++;
            if (q8.size() == 0) begin
                checks++;
                $display("FAIL spurious_done8: done at cycle %0d with nothing outstanding", cyc);
            end else begin
                e = q8.pop_front();
                checks++;
                if ({hi8, lo8, div0_8} !== {e.hi[7:0], e.lo[7:0], e.div0})
                    $display("FAIL %s: got hi=%h lo=%h div0=%b, expected hi=%h lo=%h div0=%b",
                             e.name, hi8, lo8, div0_8, e.hi[7:0], e.lo[7:0], e.div0);
                else passes++;
                checks++;
                if (cyc != e.due)
                    $display("FAIL %s_latency: done at cycle %0d, expected cycle %0d", e.name, cyc, e.due);
                else passes++;
            end
        end
    end

    task automatic issue32(input string name, input logic md, input logic sg,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo, input logic ediv0);
        exp_t e;
        @(posedge clk); #1;
        start32 = 1'b1; mode32 = md; sg32 = sg; a32 = a; b32 = b;
        e.name = name; e.hi = ehi; e.lo = elo; e.div0 = ediv0;
        e.due = cyc + 1 + (ediv0 ? 0 : 33);
        q32.push_back(e);
        if (!ediv0) begin last_hi32 = ehi; last_lo32 = elo; end
        @(posedge clk); #1;
        start32 = 1'b0;
    endtask

    task automatic issue8(input string name, input logic md, input logic sg,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ehi, input logic [7:0] elo, input logic ediv0);
        exp_t e;
        @(posedge clk); #1;
        start8 = 1'b1; mode8 = md; sg8 = sg; a8 = a; b8 = b;
        e.name = name; e.hi = {24'b0, ehi}; e.lo = {24'b0, elo}; e.div0 = ediv0;
        e.due = cyc + 1 + (ediv0 ? 0 : 9);
        q8.push_back(e);
        if (!ediv0) begin last_hi8 = ehi; last_lo8 = elo; end
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while ((q32.size() != 0 || q8.size() != 0 || busy32 || busy8) && n < budget);
        if (q32.size() != 0 || q8.size() != 0 || busy32 || busy8) begin
            checks++;
            $display("FAIL timeout: outstanding32=%0d outstanding8=%0d busy32=%b busy8=%b, expected all idle",
                     q32.size(), q8.size(), busy32, busy8);
            q32.delete();
            q8.delete();
        end
    endtask

    // Reference arithmetic for random stimulus, written with native operators
    task automatic model32(input logic md, input logic sg, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] ehi, output logic [31:0] elo, output logic ediv0);
        logic [63:0] p;
        longint sa, sb, qq, rr;
        ediv0 = 1'b0;
        if (md == MDU_MULT) begin
            if (sg) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            else    p = {32'b0, a} * {32'b0, b};
            ehi = p[63:32]; elo = p[31:0];
        end else if (b == 32'd0) begin
            ediv0 = 1'b1; ehi = last_hi32; elo = last_lo32;
        end else if (sg) begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
            qq = sa / sb; rr = sa % sb;
            ehi = rr[31:0]; elo = qq[31:0];
        end else begin
            ehi = a % b; elo = a / b;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy32, done32, div0_32, hi32, lo32} !== 67'd0)
            $display("FAIL reset32: got busy=%b done=%b div0=%b hi=%h lo=%h, expected all zero",
                     busy32, done32, div0_32, hi32, lo32);
        else passes++;
        checks++;
        if ({busy8, done8, div0_8, hi8, lo8} !== 19'd0)
            $display("FAIL reset8: got busy=%b done=%b div0=%b hi=%h lo=%h, expected all zero",
                     busy8, done8, div0_8, hi8, lo8);
        else passes++;
        reset = 1'b0;
    endtask

    task automatic test_mult32;
        issue32("umul_ffff", MDU_MULT, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        wait_idle(60);
        issue32("smul_m7x3", MDU_MULT, 1'b1, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        wait_idle(60);
    endtask

    task automatic test_div32;
        issue32("sdiv_m7d2", MDU_DIV, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        wait_idle(60);
        issue32("udiv_100d7", MDU_DIV, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        wait_idle(60);
        issue32("sdiv_ovf", MDU_DIV, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0);
        wait_idle(60);
    endtask

    task automatic test_div0;
        issue32("setup_5_9", MDU_DIV, 1'b0, 32'd68, 32'd7, 32'd5, 32'd9, 1'b0);
        wait_idle(60);
        issue32("div0_123", MDU_DIV, 1'b0, 32'd123, 32'd0, 32'd5, 32'd9, 1'b1);
        wait_idle(20);
        issue32("mul_after_div0", MDU_MULT, 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
        wait_idle(60);
    endtask

    task automatic test_random32;
        logic md, sg, ed;
        logic [31:0] a, b, eh, el;
        for (int i = 0; i < 10; i++) begin
            md = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            model32(md, sg, a, b, eh, el, ed);
            issue32($sformatf("rand32_%0d", i), md, sg, a, b, eh, el, ed);
            wait_idle(60);
        end
    endtask

    task automatic test_ignore_start;
        int d0;
        d0 = ndone32;
        issue32("mul_busy_start", MDU_MULT, 1'b0, 32'd1000, 32'd1000, 32'd0, 32'd1000000, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        start32 = 1'b1; mode32 = MDU_DIV; a32 = 32'd55; b32 = 32'd0;
        repeat (5) @(posedge clk);
        #1;
        start32 = 1'b0;
        wait_idle(60);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (ndone32 - d0 != 1)
            $display("FAIL ignore_start: got %0d done pulses, expected 1", ndone32 - d0);
        else passes++;
    endtask

    task automatic test_back_to_back;
        int n = 0;
        issue32("b2b_first", MDU_MULT, 1'b1, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd0, 32'd6, 1'b0);
        while (!done32 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!done32) begin
            checks++;
            $display("FAIL b2b_wait: done=%b, expected 1 within 60 cycles", done32);
        end
        issue32("b2b_second", MDU_DIV, 1'b0, 32'd1000, 32'd33, 32'd10, 32'd30, 1'b0);
        wait_idle(60);
    endtask

    task automatic test_reset_abort;
        int d32, d8;
        @(posedge clk); #1;
        start32 = 1'b1; mode32 = MDU_MULT; sg32 = 1'b0; a32 = 32'd77; b32 = 32'd88;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        d32 = ndone32; d8 = ndone8;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy32, done32, div0_32, hi32, lo32} !== 67'd0)
            $display("FAIL reset_abort_outputs: got busy=%b done=%b div0=%b hi=%h lo=%h, expected all zero",
                     busy32, done32, div0_32, hi32, lo32);
        else passes++;
        reset = 1'b0;
        last_hi32 = '0; last_lo32 = '0; last_hi8 = '0; last_lo8 = '0;
        repeat (45) @(posedge clk);
        #1;
        checks++;
        if (ndone32 != d32 || busy32 !== 1'b0)
            $display("FAIL reset_abort_nodone: got %0d done pulses busy=%b, expected 0 and busy=0",
                     ndone32 - d32, busy32);
        else passes++;
    endtask

    task automatic test_width8;
        issue8("w8_umul_ff", MDU_MULT, 1'b0, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b0);
        wait_idle(30);
        issue8("w8_smul_m7x3", MDU_MULT, 1'b1, 8'hF9, 8'd3, 8'hFF, 8'hEB, 1'b0);
        wait_idle(30);
        issue8("w8_sdiv_m7d2", MDU_DIV, 1'b1, 8'hF9, 8'd2, 8'hFF, 8'hFD, 1'b0);
        wait_idle(30);
        issue8("w8_udiv_100d7", MDU_DIV, 1'b0, 8'd100, 8'd7, 8'd2, 8'd14, 1'b0);
        wait_idle(30);
        issue8("w8_sdiv_ovf", MDU_DIV, 1'b1, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0);
        wait_idle(30);
        issue8("w8_div0", MDU_DIV, 1'b1, 8'd9, 8'd0, last_hi8, last_lo8, 1'b1);
        wait_idle(10);
    endtask

    initial begin
        test_reset();
        test_mult32();
        test_div32();
        test_div0();
        test_width8();
        test_ignore_start();
        test_back_to_back();
        test_random32();
        test_reset_abort();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
